// File: rtl/main_mem_pkg.sv
// rtl/main_mem_pkg.sv - shared types for the main-memory port controller
package main_mem_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
  typedef logic ch_idx_t;
  typedef enum logic {OP_RD, OP_WR} op_t;

  localparam ch_idx_t CH1 = 1'b0;
  localparam ch_idx_t CH2 = 1'b1;

  function automatic ch_idx_t other_ch(input ch_idx_t c);
    return ~c;
  endfunction

endpackage

// File: rtl/main_mem_rr_arb.sv
// rtl/main_mem_rr_arb.sv - two-way round-robin arbiter, pointer moves past each granted channel
module main_mem_rr_arb
  import main_mem_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic       o_grant_idx,
  output logic       o_grant_valid
);

  ch_idx_t r_ptr;

  always_comb begin
    o_grant_valid = |i_req;
    o_grant_idx   = i_req[r_ptr] ? r_ptr : other_ch(r_ptr);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ptr <= CH1;
    end else if (i_advance && o_grant_valid) begin
      r_ptr <= other_ch(o_grant_idx);
    end
  end

endmodule

// File: rtl/main_mem_port_ctrl.sv
// rtl/main_mem_port_ctrl.sv - serialises two read/write request channels onto one
// single-port SRAM with round-robin grants and level-held acks
module main_mem_port_ctrl
  import main_mem_pkg::*;
#(
  parameter int data_width = 32,
  parameter int addr_size  = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [addr_size-1:0]  addr1_i,
  input  logic [addr_size-1:0]  addr2_i,
  input  logic                  read_en1_i,
  input  logic                  read_en2_i,
  input  logic                  write_en1_i,
  input  logic                  write_en2_i,
  input  logic [data_width-1:0] w_data1_i,
  input  logic [data_width-1:0] w_data2_i,
  output logic [data_width-1:0] r_data1_o,
  output logic [data_width-1:0] r_data2_o,
  output logic                  read_ack1_o,
  output logic                  read_ack2_o,
  output logic                  write_ack1_o,
  output logic                  write_ack2_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [addr_size-1:0]  mem_addr_o,
  output logic [data_width-1:0] mem_wdata_o,
  input  logic [data_width-1:0] mem_rdata_i,
  output logic                  proto_err_o
);

  logic                  w_en1;
  logic                  w_en2;
  logic [1:0]            w_req;
  logic                  w_advance;
  logic                  w_grant_idx;
  logic                  w_grant_valid;
  logic                  w_grant_wr;
  logic [addr_size-1:0]  w_grant_addr;
  logic [data_width-1:0] w_grant_wdata;
  logic                  w_op_done;
  logic                  w_cmpl1;
  logic                  w_cmpl2;

  state_t                r_state;
  ch_idx_t               r_ch;
  op_t                   r_op;
  logic                  r_done1;
  logic                  r_done2;
  logic [data_width-1:0] r_rdata1;
  logic [data_width-1:0] r_rdata2;
  logic                  r_proto_err;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [addr_size-1:0]  r_mem_addr;
  logic [data_width-1:0] r_mem_wdata;

  assign w_en1 = read_en1_i | write_en1_i;
  assign w_en2 = read_en2_i | write_en2_i;
  // A finished channel stays out of arbitration until its requester drops en
  assign w_req     = {w_en2 & ~r_done2, w_en1 & ~r_done1};
  assign w_advance = (r_state == IDLE);

  assign w_grant_wr    = (w_grant_idx == CH2) ? write_en2_i : write_en1_i;
  assign w_grant_addr  = (w_grant_idx == CH2) ? addr2_i     : addr1_i;
  assign w_grant_wdata = (w_grant_idx == CH2) ? w_data2_i   : w_data1_i;

  assign w_op_done = ((r_state == ISSUE) && (r_op == OP_WR)) || (r_state == CAPTURE);
  assign w_cmpl1   = w_op_done && (r_ch == CH1);
  assign w_cmpl2   = w_op_done && (r_ch == CH2);

  main_mem_rr_arb u_arb (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .i_req         (w_req),
    .i_advance     (w_advance),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  // The mem_* registers double as the latched address/data of the granted request
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= IDLE;
      r_ch        <= CH1;
      r_op        <= OP_RD;
      r_rdata1    <= '0;
      r_rdata2    <= '0;
      r_proto_err <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      if ((read_en1_i && write_en1_i) || (read_en2_i && write_en2_i)) begin
        r_proto_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_ch        <= w_grant_idx;
            r_op        <= w_grant_wr ? OP_WR : OP_RD;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_grant_wr;
            r_mem_addr  <= w_grant_addr;
            r_mem_wdata <= w_grant_wr ? w_grant_wdata : '0;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_state <= (r_op == OP_WR) ? IDLE : CAPTURE;
        end
        CAPTURE: begin
          if (r_ch == CH2) begin
            r_rdata2 <= mem_rdata_i;
          end else begin
            r_rdata1 <= mem_rdata_i;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_done1 <= 1'b0;
      r_done2 <= 1'b0;
    end else begin
      r_done1 <= w_en1 & (r_done1 | w_cmpl1);
      r_done2 <= w_en2 & (r_done2 | w_cmpl2);
    end
  end

  assign read_ack1_o  = r_done1 & read_en1_i;
  assign read_ack2_o  = r_done2 & read_en2_i;
  assign write_ack1_o = r_done1 & write_en1_i;
  assign write_ack2_o = r_done2 & write_en2_i;
  assign r_data1_o    = r_rdata1;
  assign r_data2_o    = r_rdata2;
  assign mem_en_o     = r_mem_en;
  assign mem_we_o     = r_mem_we;
  assign mem_addr_o   = r_mem_addr;
  assign mem_wdata_o  = r_mem_wdata;
  assign proto_err_o  = r_proto_err;

endmodule

// File: tb/tb_main_mem_port_ctrl.sv
// tb/tb_main_mem_port_ctrl.sv - directed and randomized bench for main_mem_port_ctrl
module tb_main_mem_port_ctrl;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [15:0] addr1_i, addr2_i;
  logic        read_en1_i, read_en2_i, write_en1_i, write_en2_i;
  logic [31:0] w_data1_i, w_data2_i;
  logic [31:0] r_data1_o, r_data2_o;
  logic        read_ack1_o, read_ack2_o, write_ack1_o, write_ack2_o;
  logic        mem_en_o, mem_we_o;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        proto_err_o;

  int n_chk  = 0;
  int n_pass = 0;
  int sram_writes = 0;
  logic [31:0] sram  [0:255];
  logic [31:0] model [0:255];

  always #5 clk = ~clk;

  main_mem_port_ctrl dut (
    .clk_i(clk), .reset_i(reset_i),
    .addr1_i(addr1_i), .addr2_i(addr2_i),
    .read_en1_i(read_en1_i), .read_en2_i(read_en2_i),
    .write_en1_i(write_en1_i), .write_en2_i(write_en2_i),
    .w_data1_i(w_data1_i), .w_data2_i(w_data2_i),
    .r_data1_o(r_data1_o), .r_data2_o(r_data2_o),
    .read_ack1_o(read_ack1_o), .read_ack2_o(read_ack2_o),
    .write_ack1_o(write_ack1_o), .write_ack2_o(write_ack2_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .proto_err_o(proto_err_o)
  );

  // single-port synchronous SRAM: read data valid the cycle after the strobe
  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) begin
        sram[mem_addr_o[7:0]] <= mem_wdata_o;
        sram_writes <= sram_writes + 1;
      end else begin
        mem_rdata_i <= sram[mem_addr_o[7:0]];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_ch(input int c, input bit rd, input bit wr,
                          input logic [15:0] a, input logic [31:0] d);
    if (c == 0) begin
      read_en1_i = rd; write_en1_i = wr; addr1_i = a; w_data1_i = d;
    end else begin
      read_en2_i = rd; write_en2_i = wr; addr2_i = a; w_data2_i = d;
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    drive_ch(0, 0, 0, 16'h0, 32'h0);
    drive_ch(1, 0, 0, 16'h0, 32'h0);
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic wr1(input logic [15:0] a, input logic [31:0] d);
    int k;
    drive_ch(0, 0, 1, a, d);
    k = 0;
    do begin tick(); k++; end while (!write_ack1_o && k < 10);
    check_eq("wr1_ack", 32'(write_ack1_o), 32'd1);
    drive_ch(0, 0, 0, a, d);
    tick();
  endtask

  initial begin
    bit          busy [2];
    bit          isw  [2];
    logic [15:0] ra   [2];
    logic [31:0] rd   [2];
    int          age  [2];
    int          base;
    bit          q [$];

    do_reset();
    check_eq("rst_flags", 32'({mem_en_o, mem_we_o, read_ack1_o, read_ack2_o,
                               write_ack1_o, write_ack2_o, proto_err_o}), 32'd0);
    check_eq("rst_rdata", r_data1_o | r_data2_o, 32'd0);
    check_eq("rst_maddr", 32'(mem_addr_o), 32'd0);

    // single write
    drive_ch(0, 0, 1, 16'h0010, 32'hDEADBEEF);
    #1 check_eq("wr_ack_n0", 32'(write_ack1_o), 32'd0);
    tick();
    check_eq("wr_strobe", 32'({mem_en_o, mem_we_o}), 32'd3);
    check_eq("wr_addr", 32'(mem_addr_o), 32'h10);
    check_eq("wr_wdata", mem_wdata_o, 32'hDEADBEEF);
    check_eq("wr_ack_n1", 32'(write_ack1_o), 32'd0);
    tick();
    check_eq("wr_ack_n2", 32'(write_ack1_o), 32'd1);
    check_eq("wr_idle_en", 32'(mem_en_o), 32'd0);
    tick();
    check_eq("wr_ack_held", 32'(write_ack1_o), 32'd1);
    drive_ch(0, 0, 0, 16'h0010, 32'h0);
    #1 check_eq("wr_ack_drop", 32'(write_ack1_o), 32'd0);
    tick();

    // read back
    drive_ch(0, 1, 0, 16'h0010, 32'h0);
    tick();
    check_eq("rd_strobe", 32'({mem_en_o, mem_we_o}), 32'd2);
    tick();
    check_eq("rd_ack_n2", 32'(read_ack1_o), 32'd0);
    tick();
    check_eq("rd_ack_n3", 32'(read_ack1_o), 32'd1);
    check_eq("rd_data", r_data1_o, 32'hDEADBEEF);
    drive_ch(0, 0, 0, 16'h0, 32'h0);
    tick();

    // dual read from a fresh round-robin pointer
    wr1(16'h0001, 32'hA1A1A1A1);
    wr1(16'h0002, 32'hB2B2B2B2);
    do_reset();
    drive_ch(0, 1, 0, 16'h0001, 32'h0);
    drive_ch(1, 1, 0, 16'h0002, 32'h0);
    tick(); tick(); tick();
    check_eq("dual_n3", 32'({read_ack1_o, read_ack2_o}), 32'b10);
    check_eq("dual_d1", r_data1_o, 32'hA1A1A1A1);
    tick(); tick();
    check_eq("dual_n5", 32'({read_ack1_o, read_ack2_o}), 32'b10);
    tick();
    check_eq("dual_n6", 32'({read_ack1_o, read_ack2_o}), 32'b11);
    check_eq("dual_d2", r_data2_o, 32'hB2B2B2B2);
    drive_ch(0, 0, 0, 16'h0, 32'h0);
    drive_ch(1, 0, 0, 16'h0, 32'h0);
    tick();

    // round-robin with repeated writes on both channels
    do_reset();
    drive_ch(0, 0, 1, 16'h0020, 32'h11111111);
    drive_ch(1, 0, 1, 16'h0021, 32'h22222222);
    for (int i = 0; i < 40 && q.size() < 4; i++) begin
      tick();
      if (mem_en_o) q.push_back(mem_addr_o == 16'h0021);
      write_en1_i = !write_ack1_o;
      write_en2_i = !write_ack2_o;
    end
    check_eq("rr_count", 32'(q.size()), 32'd4);
    for (int i = 0; i < 4 && i < q.size(); i++)
      check_eq($sformatf("rr_grant%0d", i), 32'(q[i]), 32'(i % 2));
    drive_ch(0, 0, 0, 16'h0, 32'h0);
    drive_ch(1, 0, 0, 16'h0, 32'h0);
    tick(); tick(); tick(); tick();
    // after a lone ch1 grant the pointer favours ch2 when both contend
    wr1(16'h0022, 32'h33333333);
    drive_ch(0, 0, 1, 16'h0023, 32'h44444444);
    drive_ch(1, 0, 1, 16'h0024, 32'h55555555);
    tick();
    check_eq("rr_ptr_ch2", 32'(mem_addr_o), 32'h24);
    for (int i = 0; i < 8; i++) tick();
    check_eq("rr_both_ack", 32'({write_ack1_o, write_ack2_o}), 32'b11);
    drive_ch(0, 0, 0, 16'h0, 32'h0);
    drive_ch(1, 0, 0, 16'h0, 32'h0);
    tick();

    // abort: read_en2 dropped during capture
    wr1(16'h0005, 32'hCAFE0005);
    drive_ch(1, 1, 0, 16'h0005, 32'h0);
    tick(); tick();
    drive_ch(1, 0, 0, 16'h0005, 32'h0);
    tick();
    check_eq("abort_noack", 32'(read_ack2_o), 32'd0);
    check_eq("abort_rdata2", r_data2_o, 32'hCAFE0005);
    drive_ch(0, 1, 0, 16'h0005, 32'h0);
    tick();
    check_eq("abort_idle", 32'(mem_en_o), 32'd1);
    tick(); tick();
    check_eq("abort_rd1", r_data1_o, 32'hCAFE0005);
    drive_ch(0, 0, 0, 16'h0, 32'h0);
    tick();

    // protocol error: read and write together on ch1
    do_reset();
    base = sram_writes;
    drive_ch(0, 1, 1, 16'h0030, 32'h12345678);
    tick();
    check_eq("err_we", 32'({mem_en_o, mem_we_o}), 32'd3);
    tick();
    check_eq("err_wack", 32'(write_ack1_o), 32'd1);
    drive_ch(0, 0, 0, 16'h0, 32'h0);
    tick(); tick(); tick();
    check_eq("err_sticky", 32'(proto_err_o), 32'd1);
    check_eq("err_nwrites", 32'(sram_writes - base), 32'd1);
    check_eq("err_sram", sram[8'h30], 32'h12345678);

    // reset while in ISSUE
    drive_ch(1, 0, 1, 16'h0031, 32'h9);
    tick();
    check_eq("rst_mid_issue", 32'(mem_en_o), 32'd1);
    reset_i = 1'b1;
    drive_ch(1, 0, 0, 16'h0, 32'h0);
    tick();
    check_eq("rst_mid_outs", 32'({mem_en_o, mem_we_o, write_ack2_o, proto_err_o}), 32'd0);
    check_eq("rst_mid_addr", 32'(mem_addr_o), 32'd0);
    reset_i = 1'b0;
    tick();

    // randomized traffic; each channel owns 8 addresses so grant order never matters
    for (int i = 0; i < 16; i++) begin
      model[8'h40 + i] = $urandom;
      wr1(16'h0040 + 16'(i), model[8'h40 + i]);
    end
    for (int c = 0; c < 2; c++) begin busy[c] = 0; age[c] = 0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      for (int c = 0; c < 2; c++) begin
        logic rack, wack;
        rack = (c == 0) ? read_ack1_o : read_ack2_o;
        wack = (c == 0) ? write_ack1_o : write_ack2_o;
        if (busy[c]) begin
          age[c]++;
          if (isw[c] ? wack : rack) begin
            check_eq($sformatf("rnd_lat_ch%0d", c + 1), 32'(age[c] <= 6), 32'd1);
            if (isw[c]) begin
              model[ra[c][7:0]] = rd[c];
              check_eq("rnd_wr_no_rack", 32'(rack), 32'd0);
            end else begin
              check_eq($sformatf("rnd_rdata_ch%0d", c + 1),
                       (c == 0) ? r_data1_o : r_data2_o, model[ra[c][7:0]]);
            end
            busy[c] = 0;
            drive_ch(c, 0, 0, ra[c], rd[c]);
          end else if (age[c] >= 10) begin
            check_eq($sformatf("rnd_timeout_ch%0d", c + 1), 32'(isw[c] ? wack : rack), 32'd1);
            busy[c] = 0;
            drive_ch(c, 0, 0, ra[c], rd[c]);
          end
        end else if ($urandom_range(0, 2) == 0) begin
          isw[c]  = $urandom_range(0, 1) == 1;
          ra[c]   = 16'h0040 + 16'(c * 8) + 16'($urandom_range(0, 7));
          rd[c]   = $urandom;
          age[c]  = 0;
          busy[c] = 1;
          drive_ch(c, !isw[c], isw[c], ra[c], rd[c]);
        end
      end
    end
    check_eq("rnd_no_err", 32'(proto_err_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
